mu0_arb_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshaking. It is the next-generation datapath selector for the MU0 family, replacing fixed 2:1 combinational select where several sources (PC, IR address field, DMA, debug) compete for one 12-bit bus. It buffers one word in an output register, so source and sink timing are decoupled by one cycle. A force mode reproduces plain select behaviour, with the select value supplied externally.

---
 rtl/mu0_arb_mux.sv | 101 ++++++++++
 tb/tb_mu0_arb_mux.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_arb_mux.sv
// Round-robin (or force-selected) N:1 mux into a single registered output word.
// One-cycle latency; full throughput when the sink keeps Out_Ready high.
module mu0_arb_mux #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    localparam int CHAN_W  = $clog2(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    input  logic                      Force_En,
    input  logic [CHAN_W-1:0]         Force_Sel,
    output logic [WIDTH-1:0]          Out_Data,
    output logic [CHAN_W-1:0]         Out_Chan,
    output logic                      Out_Valid,
    input  logic                      Out_Ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [CHAN_W-1:0]   out_chan_q, out_chan_d;
    logic [CHAN_W-1:0]   last_q, last_d;
    logic                load;
    logic                gnt_any;
    logic [CHAN_W-1:0]   gnt_idx;
    logic [CHAN_W-1:0]   cand;

    assign load = (state_q == EMPTY) || Out_Ready;

    // Descending search so the nearest channel after last_q is the final winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (Force_En) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (Force_Sel == CHAN_W'(i) && In_Valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CHAN_W'(i);
                end
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                cand = CHAN_W'((int'(last_q) + k) % CHANNELS);
                if (In_Valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        In_Ready = '0;
        if (load && gnt_any) begin
            In_Ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        last_d     = last_q;
        if (load) begin
            if (gnt_any) begin
                state_d    = FULL;
                out_data_d = In_Data[gnt_idx*WIDTH +: WIDTH];
                out_chan_d = gnt_idx;
                last_d     = gnt_idx;
            end else begin
                state_d    = EMPTY;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_chan_q <= '0;
            last_q     <= CHAN_W'(CHANNELS - 1);
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        Out_Valid = (state_q == FULL);
        Out_Data  = out_data_q;
        Out_Chan  = out_chan_q;
    end

endmodule

// File: tb/tb_mu0_arb_mux.sv
// Bench for mu0_arb_mux: 4x12 instance driven from a vector table with a scoreboard,
// plus a 3x16 instance exercising wrap-around and out-of-range force select.
module tb_mu0_arb_mux;

    logic        Clk = 1'b0;
    logic        nReset = 1'b1;
    always #5 Clk = ~Clk;

    // 4-channel, 12-bit instance
    logic [11:0] dat_a [4];
    logic [47:0] in_data_a;
    logic [3:0]  in_valid_a = '0, in_ready_a;
    logic        force_en_a = 1'b0, out_valid_a, out_ready_a = 1'b0;
    logic [1:0]  force_sel_a = '0, out_chan_a;
    logic [11:0] out_data_a;
    assign in_data_a = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

    mu0_arb_mux #(.WIDTH(12), .CHANNELS(4)) dut_a (
        .Clk(Clk), .nReset(nReset), .In_Data(in_data_a), .In_Valid(in_valid_a),
        .In_Ready(in_ready_a), .Force_En(force_en_a), .Force_Sel(force_sel_a),
        .Out_Data(out_data_a), .Out_Chan(out_chan_a), .Out_Valid(out_valid_a),
        .Out_Ready(out_ready_a)
    );

    // 3-channel, 16-bit instance
    logic [15:0] dat_b [3];
    logic [47:0] in_data_b;
    logic [2:0]  in_valid_b = '0, in_ready_b;
    logic        force_en_b = 1'b0, out_valid_b, out_ready_b = 1'b0;
    logic [1:0]  force_sel_b = '0, out_chan_b;
    logic [15:0] out_data_b;
    assign in_data_b = {dat_b[2], dat_b[1], dat_b[0]};

    mu0_arb_mux #(.WIDTH(16), .CHANNELS(3)) dut_b (
        .Clk(Clk), .nReset(nReset), .In_Data(in_data_b), .In_Valid(in_valid_b),
        .In_Ready(in_ready_b), .Force_En(force_en_b), .Force_Sel(force_sel_b),
        .Out_Data(out_data_b), .Out_Chan(out_chan_b), .Out_Valid(out_valid_b),
        .Out_Ready(out_ready_b)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          chan;
        logic [11:0] data;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic       fe;
        logic [1:0] fs;
        logic [3:0] rdy;
    } vec_t;
    vec_t tbl [24];

    // Reference model of the 4-channel instance
    logic m_valid = 1'b0;
    int   m_last  = 3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle of stimulus on instance A.
    task automatic step(input logic [3:0] v, input logic r, input logic fe,
                        input logic [1:0] fs, input logic [3:0] exp_rdy, input string nm);
        int   g;
        logic ld;
        sb_t  e;
        in_valid_a  = v;
        out_ready_a = r;
        force_en_a  = fe;
        force_sel_a = fs;
        #2;
        chk({nm, "_in_ready"}, 32'(in_ready_a), 32'(exp_rdy));
        g = -1;
        if (fe) begin
            if (v[fs]) g = int'(fs);
        end else begin
            for (int k = 4; k >= 1; k--) begin
                if (v[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
        end
        ld = !m_valid || r;
        if (m_valid) begin
            chk({nm, "_out_valid_pre"}, 32'(out_valid_a), 32'd1);
            if (r) begin
                if (sb.size() == 0) begin
                    chk({nm, "_sb_nonempty"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({nm, "_out_chan"}, 32'(out_chan_a), 32'(e.chan));
                    chk({nm, "_out_data"}, 32'(out_data_a), 32'(e.data));
                end
            end
        end
        @(posedge Clk);
        #1;
        if (ld && g >= 0) begin
            e.chan = g;
            e.data = dat_a[g];
            sb.push_back(e);
            m_valid = 1'b1;
            m_last  = g;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        chk({nm, "_out_valid_post"}, 32'(out_valid_a), 32'(m_valid));
    endtask

    task automatic reset_model();
        m_valid = 1'b0;
        m_last  = 3;
        sb.delete();
    endtask

    initial begin
        int seq_b [4];
        seq_b = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) dat_a[i] = 12'h100 + 12'(i);
        for (int i = 0; i < 3; i++) dat_b[i] = 16'hB000 + 16'(i);

        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100};
        tbl[8]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[11] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000};
        tbl[12] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[13] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[14] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[15] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100};
        tbl[16] = '{4'b0111, 1'b1, 1'b1, 2'd3, 4'b0000};
        tbl[17] = '{4'b0111, 1'b1, 1'b1, 2'd3, 4'b0000};
        tbl[18] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000};
        tbl[19] = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[20] = '{4'b0011, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[21] = '{4'b0011, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[22] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001};
        tbl[23] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

        #1 nReset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'd0);
        chk("rst_out_chan", 32'(out_chan_a), 32'd0);
        chk("rst_b_out_valid", 32'(out_valid_b), 32'd0);
        repeat (2) @(posedge Clk);
        #1 nReset = 1'b1;

        // Single source on channel 2
        dat_a[2] = 12'hABC;
        step(4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, "single");
        chk("single_data", 32'(out_data_a), 32'hABC);
        chk("single_chan", 32'(out_chan_a), 32'd2);
        step(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "single_drain");
        dat_a[2] = 12'h102;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].fe, tbl[i].fs, tbl[i].rdy, $sformatf("vec%0d", i));
        end

        // Backpressure holding 0x555, then same-cycle drain and reload
        dat_a[1] = 12'h555;
        step(4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, "bp_load");
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, $sformatf("bp_hold%0d", i));
            chk("bp_hold_data", 32'(out_data_a), 32'h555);
            chk("bp_hold_chan", 32'(out_chan_a), 32'd1);
        end
        step(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, "bp_release");
        chk("bp_release_chan", 32'(out_chan_a), 32'd2);
        dat_a[1] = 12'h101;

        // Asynchronous reset with a word held, away from any clock edge
        #2 nReset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_out_data", 32'(out_data_a), 32'd0);
        chk("midrst_out_chan", 32'(out_chan_a), 32'd0);
        reset_model();
        @(posedge Clk);
        #1 nReset = 1'b1;
        step(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, "post_rst0");
        step(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, "post_rst1");
        step(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, "post_rst2");
        step(4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, "post_rst3");
        step(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "post_rst_drain");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Three-channel instance: wrap-around and no grant to index 3
        in_valid_b  = 3'b111;
        out_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("b_rr%0d_ready", i), 32'(in_ready_b), 32'(1 << seq_b[i]));
            @(posedge Clk);
            #1;
            chk($sformatf("b_rr%0d_chan", i), 32'(out_chan_b), 32'(seq_b[i]));
            chk($sformatf("b_rr%0d_data", i), 32'(out_data_b), 32'(16'hB000 + 16'(seq_b[i])));
            chk($sformatf("b_rr%0d_valid", i), 32'(out_valid_b), 32'd1);
        end
        force_en_b  = 1'b1;
        force_sel_b = 2'd3;
        #2;
        chk("b_force3_ready", 32'(in_ready_b), 32'd0);
        @(posedge Clk);
        #1;
        chk("b_force3_valid", 32'(out_valid_b), 32'd0);
        force_en_b  = 1'b0;
        force_sel_b = 2'd0;
        #2;
        chk("b_resume_ready", 32'(in_ready_b), 32'b010);
        @(posedge Clk);
        #1;
        chk("b_resume_chan", 32'(out_chan_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
